// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and constants for the VGA tile renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef shortint coord_t;

    localparam int          PIPE_LAT         = 4;
    localparam logic [11:0] BG_COLOR_DEFAULT = 12'h000;

    // True when a lies within +/-half of center (computed in int to avoid wrap).
    function automatic logic near_axis(input coord_t a, input coord_t center, input coord_t half);
        int d;
        d = int'(a) - int'(center);
        return (d <= int'(half)) && (d >= -int'(half));
    endfunction

    function automatic rgb_t rgb_invert(input rgb_t c);
        rgb_t o;
        o.r = 4'hF - c.r;
        o.g = 4'hF - c.g;
        o.b = 4'hF - c.b;
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Resettable W-bit wide, DEPTH-deep shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] r_stage;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_stage <= '0;
                else     r_stage <= d;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) r_stage <= '0;
                else     r_stage <= {r_stage[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : vga_tile_renderer
// Description : 4-stage tile-map/texture pixel pipeline feeding a 4:4:4 DAC.
//               Define VGA_CROSSHAIR_EN to overlay an inverting crosshair.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480,
    parameter int          TILE_W   = 16,
    parameter int          TILE_H   = 16,
    parameter int          MAP_COLS = 40,
    parameter int          MAP_ROWS = 30,
    parameter int          IDX_W    = 8,
    parameter logic [11:0] BG_COLOR = BG_COLOR_DEFAULT,
    parameter int          CH_LEN   = 8,
    localparam int         MA_W     = $clog2(MAP_COLS*MAP_ROWS),
    localparam int         TA_W     = IDX_W + $clog2(TILE_W*TILE_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic signed [15:0] in_x,
    input  logic signed [15:0] in_y,
    input  logic               in_visible,
    output logic [MA_W-1:0]    map_addr,
    input  logic [IDX_W-1:0]   map_data,
    output logic [TA_W-1:0]    tex_addr,
    input  logic [11:0]        tex_data,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic [3:0]         out_r,
    output logic [3:0]         out_g,
    output logic [3:0]         out_b,
    output logic               frame_start
);

    localparam int          c_TX_W     = $clog2(TILE_W);
    localparam int          c_TY_W     = $clog2(TILE_H);
    localparam logic [15:0] c_MAP_COLS = 16'(MAP_COLS);
    localparam logic [15:0] c_MAP_ROWS = 16'(MAP_ROWS);

    // ---------------- S0: tile coordinate and map address ----------------
    logic [15:0]     w_tcol;
    logic [15:0]     w_trow;
    logic            w_onmap;
    logic [MA_W-1:0] w_map_lin;
    logic            w_fs0;

    // Negative coordinates are excluded via the sign bit before the unsigned shift.
    assign w_tcol    = $unsigned(in_x) >> c_TX_W;
    assign w_trow    = $unsigned(in_y) >> c_TY_W;
    assign w_onmap   = in_visible && !in_x[15] && !in_y[15] &&
                       (w_tcol < c_MAP_COLS) && (w_trow < c_MAP_ROWS);
    assign w_map_lin = MA_W'(w_trow) * MA_W'(MAP_COLS) + MA_W'(w_tcol);
    assign w_fs0     = in_visible && (in_x == 16'sd0) && (in_y == 16'sd0);

    logic              r_s0_vis;
    logic              r_s0_onmap;
    logic [c_TX_W-1:0] r_s0_xlo;
    logic [c_TY_W-1:0] r_s0_ylo;

    always_ff @(posedge clk) begin
        if (rst) begin
            map_addr   <= '0;
            r_s0_vis   <= 1'b0;
            r_s0_onmap <= 1'b0;
            r_s0_xlo   <= '0;
            r_s0_ylo   <= '0;
        end else begin
            map_addr   <= w_onmap ? w_map_lin : '0;
            r_s0_vis   <= in_visible;
            r_s0_onmap <= w_onmap;
            r_s0_xlo   <= in_x[c_TX_W-1:0];
            r_s0_ylo   <= in_y[c_TY_W-1:0];
        end
    end

    // ---------------- S1: tile index in, texel address out ----------------
    logic r_s1_vis;
    logic r_s1_onmap;
    logic r_s1_tile0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tex_addr   <= '0;
            r_s1_vis   <= 1'b0;
            r_s1_onmap <= 1'b0;
            r_s1_tile0 <= 1'b0;
        end else begin
            tex_addr   <= {map_data, r_s0_ylo, r_s0_xlo};
            r_s1_vis   <= r_s0_vis;
            r_s1_onmap <= r_s0_onmap;
            r_s1_tile0 <= (map_data == '0);
        end
    end

    // ---------------- S2: texel in, base colour resolved ----------------
    rgb_t w_s2_color;
    rgb_t r_s2_color;

    always_comb begin
        w_s2_color = '0;
        if (r_s1_vis) begin
            w_s2_color = (!r_s1_onmap || r_s1_tile0) ? rgb_t'(BG_COLOR) : rgb_t'(tex_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_s2_color <= '0;
        else     r_s2_color <= w_s2_color;
    end

    // ---------------- S3: output register ----------------
    rgb_t w_s3_color;
    rgb_t r_out_rgb;

`ifdef VGA_CROSSHAIR_EN
    localparam coord_t c_CX = coord_t'(WIDTH / 2);
    localparam coord_t c_CY = coord_t'(HEIGHT / 2);
    localparam coord_t c_CH = coord_t'(CH_LEN);

    coord_t r_s0_x, r_s0_y, r_s1_x, r_s1_y, r_s2_x, r_s2_y;
    logic   r_s2_vis;
    logic   w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_x   <= '0;
            r_s0_y   <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s2_x   <= '0;
            r_s2_y   <= '0;
            r_s2_vis <= 1'b0;
        end else begin
            r_s0_x   <= in_x;
            r_s0_y   <= in_y;
            r_s1_x   <= r_s0_x;
            r_s1_y   <= r_s0_y;
            r_s2_x   <= r_s1_x;
            r_s2_y   <= r_s1_y;
            r_s2_vis <= r_s1_vis;
        end
    end

    assign w_hit = r_s2_vis &&
                   (((r_s2_x == c_CX) && near_axis(r_s2_y, c_CY, c_CH)) ||
                    ((r_s2_y == c_CY) && near_axis(r_s2_x, c_CX, c_CH)));

    always_comb begin
        w_s3_color = r_s2_color;
        if (w_hit) w_s3_color = rgb_invert(r_s2_color);
    end
`else
    always_comb begin
        w_s3_color = r_s2_color;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) r_out_rgb <= '0;
        else     r_out_rgb <= w_s3_color;
    end

    assign out_r = r_out_rgb.r;
    assign out_g = r_out_rgb.g;
    assign out_b = r_out_rgb.b;

    // Sync and frame marker bypass the memories but share the same latency.
    vga_delay_line #(
        .W     (3),
        .DEPTH (PIPE_LAT)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({in_hsync, in_vsync, w_fs0}),
        .q   ({out_hsync, out_vsync, frame_start})
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_tile_renderer
// Description : Directed vector-table bench for vga_tile_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_tile_renderer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_hsync, in_vsync, in_visible;
    logic signed [15:0] in_x, in_y;
    logic [10:0]        map_addr;
    logic [7:0]         map_data;
    logic [15:0]        tex_addr;
    logic [11:0]        tex_data;
    logic               out_hsync, out_vsync, frame_start;
    logic [3:0]         out_r, out_g, out_b;

    logic [7:0]  map_mem [0:2047];
    logic [11:0] tex_mem [0:65535];

    assign map_data = map_mem[map_addr];
    assign tex_data = tex_mem[tex_addr];

    always #20 clk = ~clk;

    vga_tile_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_visible  (in_visible),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .tex_addr    (tex_addr),
        .tex_data    (tex_data),
        .out_hsync   (out_hsync),
        .out_vsync   (out_vsync),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .frame_start (frame_start)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic               vis;
        logic               hs;
        logic               vs;
        logic [11:0]        rgb;
        logic               fs;
    } vec_t;

    vec_t vecs [16];
    int   nvec;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic vis, input logic hs, input logic vs);
        in_x       = x;
        in_y       = y;
        in_visible = vis;
        in_hsync   = hs;
        in_vsync   = vs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] outs();
        return {out_hsync, out_vsync, frame_start, out_r, out_g, out_b};
    endfunction

    // Streams the table one pixel per clock; vector i appears at the outputs 4 clocks later.
    task automatic run_table(input string tag);
        for (int i = 0; i < nvec + 4; i++) begin
            if (i < nvec) drive(vecs[i].x, vecs[i].y, vecs[i].vis, vecs[i].hs, vecs[i].vs);
            else          drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
            if (i >= 4) begin
                check($sformatf("%s vec%0d", tag, i - 4), 32'(outs()),
                      32'({vecs[i-4].hs, vecs[i-4].vs, vecs[i-4].fs, vecs[i-4].rgb}));
            end
            tick();
        end
    endtask

    function automatic vec_t mk(input int x, input int y, input logic vis, input logic hs,
                                input logic vs, input logic [11:0] rgb, input logic fs);
        vec_t v;
        v.x = 16'(x); v.y = 16'(y); v.vis = vis; v.hs = hs; v.vs = vs; v.rgb = rgb; v.fs = fs;
        return v;
    endfunction

    initial begin
        int fs_count;
        logic [2:0] sync_hist [0:7];
        logic       vis_hist  [0:7];
        int cyc;

        for (int i = 0; i < 2048; i++)  map_mem[i] = 8'd5;
        for (int i = 0; i < 65536; i++) tex_mem[i] = 12'h111;
        map_mem[1]     = 8'd0;     // cell (1,0) holds the empty tile
        map_mem[1199]  = 8'd7;     // bottom-right cell
        tex_mem[16'h0523] = 12'hABC;
        tex_mem[16'h0513] = 12'h9A4;
        tex_mem[16'h07FF] = 12'hDEF;

        // Reset state
        rst = 1'b1;
        drive(16'sd3, 16'sd2, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("reset outs", 32'(outs()), 32'd0);
        check("reset map_addr", 32'(map_addr), 32'd0);
        check("reset tex_addr", 32'(tex_addr), 32'd0);
        rst = 1'b0;
        drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        // Main directed table
        nvec = 0;
        vecs[nvec++] = mk(3,   2,   1, 1, 1, 12'hABC, 0);
        vecs[nvec++] = mk(0,   0,   1, 0, 0, 12'h111, 1);
        vecs[nvec++] = mk(20,  0,   1, 1, 0, 12'h000, 0);
        vecs[nvec++] = mk(-10, 0,   0, 0, 1, 12'h000, 0);
        vecs[nvec++] = mk(639, 479, 1, 0, 0, 12'hDEF, 0);
        vecs[nvec++] = mk(3,   2,   0, 1, 1, 12'h000, 0);
        vecs[nvec++] = mk(640, 0,   1, 0, 0, 12'h000, 0);
        vecs[nvec++] = mk(0,   480, 1, 0, 1, 12'h000, 0);
        vecs[nvec++] = mk(0,   0,   0, 1, 0, 12'h000, 0);
        vecs[nvec++] = mk(19,  17,  1, 0, 0, 12'h9A4, 0);
        run_table("base");

        // Address outputs
        drive(16'sd19, 16'sd17, 1'b1, 1'b0, 1'b0);
        tick();
        check("map_addr cell(1,1)", 32'(map_addr), 32'd41);
        drive(-16'sd10, 16'sd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("map_addr blank", 32'(map_addr), 32'd0);
        check("tex_addr tile5 (3,1)", 32'(tex_addr), 32'h0513);
        drive(16'sd639, 16'sd479, 1'b1, 1'b0, 1'b0);
        tick();
        check("map_addr last cell", 32'(map_addr), 32'd1199);
        drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        // Reset mid-line
        drive(16'sd3, 16'sd2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("pre-reset pixel", 32'(outs()), 32'({3'b100, 12'hABC}));
        rst = 1'b1;
        tick();
        check("mid reset outs", 32'(outs()), 32'd0);
        check("mid reset map_addr", 32'(map_addr), 32'd0);
        check("mid reset tex_addr", 32'(tex_addr), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("post reset flush %0d", k), 32'(outs()), 32'd0);
        end
        tick();
        check("post reset resume", 32'(outs()), 32'({3'b100, 12'hABC}));
        drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        // Two short frames: 800-clock lines, 8 visible of 12 lines, checked every clock
        fs_count = 0;
        cyc      = 0;
        for (int i = 0; i < 8; i++) begin
            sync_hist[i] = 3'b000;
            vis_hist[i]  = 1'b0;
        end
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < 12; v++) begin
                for (int h = 0; h < 800; h++) begin
                    logic vis, hs, vs, fs;
                    vis = (h < 640) && (v < 8);
                    hs  = (h >= 656) && (h < 752);
                    vs  = (v >= 9) && (v < 11);
                    fs  = vis && (h == 0) && (v == 0);
                    drive(16'((h < 640) ? h : h - 800), 16'(v), vis, hs, vs);
                    sync_hist[cyc % 8] = {hs, vs, fs};
                    vis_hist[cyc % 8]  = vis;
                    if (cyc >= 4) begin
                        check($sformatf("frame sync c%0d", cyc),
                              32'({out_hsync, out_vsync, frame_start}), 32'(sync_hist[(cyc - 4) % 8]));
                        if (!vis_hist[(cyc - 4) % 8])
                            check($sformatf("frame blank rgb c%0d", cyc),
                                  32'({out_r, out_g, out_b}), 32'd0);
                    end
                    if (frame_start) fs_count++;
                    cyc++;
                    tick();
                end
            end
        end
        check("frame_start count", 32'(fs_count), 32'd2);
        drive(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();

`ifdef VGA_CROSSHAIR_EN
        for (int i = 0; i < 2048; i++)  map_mem[i] = 8'd5;
        for (int i = 0; i < 65536; i++) tex_mem[i] = 12'h123;
        nvec = 0;
        vecs[nvec++] = mk(320, 240, 1, 0, 0, 12'hEDC, 0);
        vecs[nvec++] = mk(328, 240, 1, 0, 0, 12'hEDC, 0);
        vecs[nvec++] = mk(329, 240, 1, 0, 0, 12'h123, 0);
        vecs[nvec++] = mk(312, 240, 1, 0, 0, 12'hEDC, 0);
        vecs[nvec++] = mk(311, 240, 1, 0, 0, 12'h123, 0);
        vecs[nvec++] = mk(320, 248, 1, 0, 0, 12'hEDC, 0);
        vecs[nvec++] = mk(320, 249, 1, 0, 0, 12'h123, 0);
        vecs[nvec++] = mk(320, 240, 0, 0, 0, 12'h000, 0);
        run_table("crosshair");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Pixel stage directly downstream of the VGA timing counter.
- Consumes hsync/vsync/x/y/visible and looks up a tile index in a tile-map RAM, then a texel in a texture RAM.
- Drives 4:4:4 RGB to the DAC pins with sync delayed to stay pixel-aligned.
- Fixed-latency 4-stage pipeline, one pixel per clk (25 MHz), no stalls.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
TILE_W, 16, tile width in pixels, power of two
TILE_H, 16, tile height in pixels, power of two
MAP_COLS, 40, tile-map columns
MAP_ROWS, 30, tile-map rows
IDX_W, 8, tile index width
BG_COLOR, 12'h000, colour for tile index 0 and off-map pixels
CH_LEN, 8, crosshair half-length in pixels (optional feature only)

Ports:
clk  in  1  pixel clock
rst  in  1  reset
in_hsync  in  1  hsync from counter, active-high during pulse
in_vsync  in  1  vsync from counter
in_x  in  16 signed  pixel column, negative in blanking
in_y  in  16 signed  pixel row
in_visible  in  1  pixel inside active area
map_addr  out  $clog2(MAP_COLS*MAP_ROWS)  tile-map read address
map_data  in  IDX_W  tile index, valid 1 clk after map_addr
tex_addr  out  IDX_W+$clog2(TILE_W*TILE_H)  texture read address
tex_data  in  12  texel {r,g,b}, valid 1 clk after tex_addr
out_hsync  out  1  delayed hsync
out_vsync  out  1  delayed vsync
out_r, out_g, out_b  out  4 each  colour
frame_start  out  1  one-clk pulse with first visible pixel of a frame

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Flops are posedge clk.
- On rst, all pipeline valid bits, out_* and frame_start go to 0; map_addr and tex_addr go to 0.
- Latency: exactly 4 clk from in_* to out_* for every signal, including syncs and frame_start.
- S0 (register inputs):
  - tcol = x >> log2(TILE_W); trow = y >> log2(TILE_H).
  - onmap = visible && tcol < MAP_COLS && trow < MAP_ROWS.
  - map_addr = onmap ? trow*MAP_COLS + tcol : 0. The multiply is by a constant and fits the address width.
- S1: map_data arrives.
  - tex_addr = {map_data, y[log2 TILE_H-1:0], x[log2 TILE_W-1:0]}.
  - Record tile0 = (map_data == 0).
- S2: tex_data arrives.
  - colour = !visible ? 0 : (!onmap || tile0) ? BG_COLOR : tex_data.
- S3: output register for colour, syncs and frame_start.
- Blanking: RGB is forced to 0 whenever the delayed visible is 0, regardless of memory contents.
- frame_start is asserted at S3 for the pixel with x==0, y==0, visible==1. It never asserts otherwise.
- Sync polarity is passed through unchanged; the block does not invert.
- Reset mid-frame: the pipeline is flushed, outputs are held at 0 during rst, and the first in_* sampled after rst deassert appears 4 clk later.
- No state machine beyond the pipeline; the block is purely streaming. Address outputs are registered.

Optional Feature:
- Macro: VGA_CROSSHAIR_EN.
- When defined, S3 inverts the RGB (each channel 15-c) for visible pixels where either:
  - x==WIDTH/2 and |y-HEIGHT/2| <= CH_LEN, or
  - y==HEIGHT/2 and |x-WIDTH/2| <= CH_LEN.
- x and y are carried through the pipeline for this test. Latency is unchanged.
- When undefined, no x/y carry flops beyond S1 are built and the output equals the base colour.

Decomposition:
- Package vga_pkg holds:
  - rgb_t, a packed struct of 3×4-bit channels;
  - coord_t, shortint;
  - constants PIPE_LAT=4 and BG_COLOR_DEFAULT.
- One sub-module, vga_delay_line: parameterised width and depth shift register used for sync/visible/frame_start alignment.

Test Plan:
- Map all index 5; texture tile 5 texel (3,2)=12'hABC; drive x=3, y=2, visible=1 → 4 clk later RGB=A,B,C.
- Tile index 0 at map cell (1,0); drive x=20, y=0 → output BG_COLOR. Drive x=-10, visible=0 → RGB=0 and map_addr=0.
- Toggle in_hsync at cycle N → out_hsync toggles at exactly N+4; same for vsync. Check over a full 800×521 frame.
- x=0, y=0, visible=1 → frame_start high exactly one clk, 4 clk later, once per frame.
- Assert rst for 1 clk mid-line → all outputs 0 next clk; valid pixels resume 4 clk after deassert.
- With VGA_CROSSHAIR_EN, texel 12'h123 everywhere → (320,240) and (328,240) output EDC; (329,240) outputs 123.
